// File: rtl/dcmac_reset_seq_if.sv
// Control/status bundle between the DCMAC register file and the reset sequencer.
// The register file is the master: it issues start/mode/chan_mask and reads status back.
interface dcmac_reset_seq_if #(
    parameter int NCH = 4
);
    logic           start;
    logic [1:0]     mode;
    logic [NCH-1:0] chan_mask;
    logic           busy;
    logic           done;
    logic           timeout;
    logic [2:0]     seq_state;

    modport master (
        output start, mode, chan_mask,
        input  busy, done, timeout, seq_state
    );

    modport slave (
        input  start, mode, chan_mask,
        output busy, done, timeout, seq_state
    );
endinterface

// File: rtl/dcmac_reset_seq.sv
// Self-timed DCMAC reset sequencer: assert, hold, release GT/serdes,
// wait for per-channel reset-done, then release the cores.
module dcmac_reset_seq #(
    parameter int NCH            = 4,
    parameter int HOLD_CYCLES    = 256,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CW             = 24
) (
    input  logic           clk,
    input  logic           resetn,
    dcmac_reset_seq_if.slave ctrl,
    input  logic [NCH-1:0] rx_reset_done,
    input  logic [NCH-1:0] tx_reset_done,
    output logic           gt_reset_all,
    output logic           gt_reset_rx_datapath,
    output logic           gt_reset_tx_datapath,
    output logic [NCH-1:0] rx_serdes_reset,
    output logic [NCH-1:0] tx_serdes_reset,
    output logic [NCH-1:0] rx_core_reset,
    output logic [NCH-1:0] tx_core_reset
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ASSERT   = 3'd1,
        S_HOLD     = 3'd2,
        S_WAIT     = 3'd3,
        S_REL_CORE = 3'd4,
        S_ERR      = 3'd6
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_t         state;
    logic [1:0]     mode_q;
    logic [NCH-1:0] mask_q;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic [CW-1:0]  hold_end;
    logic           core_only;
    logic           full_mode;
    logic           done_ok;
    logic           busy_q;
    logic           done_q;
    logic           timeout_q;
    logic [NCH-1:0] rx_meta;
    logic [NCH-1:0] rx_sync;
    logic [NCH-1:0] tx_meta;
    logic [NCH-1:0] tx_sync;

    assign core_only = (mode_q == 2'd2);
    assign full_mode = (mode_q == 2'd0) || (mode_q == 2'd3);
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    // Core-only mode leaves HOLD one cycle earlier because the extra REL_CORE
    // cycle makes up the difference: every reset is held HOLD_CYCLES+1 cycles.
    assign hold_end  = core_only ? HOLD_LAST : HOLD_END;
    assign done_ok   = ((rx_sync & mask_q) == mask_q) && ((tx_sync & mask_q) == mask_q);

    assign ctrl.busy      = busy_q;
    assign ctrl.done      = done_q;
    assign ctrl.timeout   = timeout_q;
    assign ctrl.seq_state = state;

    // Two-flop synchronisers bringing the GT reset-done flags into clk.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta <= '0;
            rx_sync <= '0;
            tx_meta <= '0;
            tx_sync <= '0;
        end else begin
            rx_meta <= rx_reset_done;
            rx_sync <= rx_meta;
            tx_meta <= tx_reset_done;
            tx_sync <= tx_meta;
        end
    end

    // Sequencer FSM with registered reset and status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state                <= S_IDLE;
            mode_q               <= '0;
            mask_q               <= '0;
            cnt                  <= '0;
            busy_q               <= 1'b0;
            done_q               <= 1'b0;
            timeout_q            <= 1'b0;
            gt_reset_all         <= 1'b0;
            gt_reset_rx_datapath <= 1'b0;
            gt_reset_tx_datapath <= 1'b0;
            rx_serdes_reset      <= '0;
            tx_serdes_reset      <= '0;
            rx_core_reset        <= '0;
            tx_core_reset        <= '0;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (ctrl.start) begin
                        mode_q    <= ctrl.mode;
                        mask_q    <= ctrl.chan_mask;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        state     <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    gt_reset_all         <= full_mode;
                    gt_reset_rx_datapath <= !core_only;
                    gt_reset_tx_datapath <= !core_only;
                    rx_serdes_reset      <= core_only ? '0 : mask_q;
                    tx_serdes_reset      <= core_only ? '0 : mask_q;
                    rx_core_reset        <= mask_q;
                    tx_core_reset        <= mask_q;
                    cnt                  <= '0;
                    state                <= S_HOLD;
                end
                S_HOLD: begin
                    if (cnt == hold_end) begin
                        if (core_only) begin
                            state <= S_REL_CORE;
                        end else begin
                            gt_reset_all         <= 1'b0;
                            gt_reset_rx_datapath <= 1'b0;
                            gt_reset_tx_datapath <= 1'b0;
                            rx_serdes_reset      <= '0;
                            tx_serdes_reset      <= '0;
                            cnt                  <= '0;
                            state                <= S_WAIT;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_WAIT: begin
                    if (done_ok) begin
                        state <= S_REL_CORE;
                    end else if (cnt == WAIT_LAST) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= S_ERR;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_REL_CORE: begin
                    rx_core_reset <= '0;
                    tx_core_reset <= '0;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    state         <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcmac_reset_seq.sv
// Self-checking bench for dcmac_reset_seq: directed and randomized sequences
// compared cycle by cycle against a closed-form timeline of the sequence.
module tb_dcmac_reset_seq;

    localparam int NCH = 4;
    localparam int H   = 8;
    localparam int TO  = 16;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [NCH-1:0] rx_done;
    logic [NCH-1:0] tx_done;
    logic           gt_reset_all;
    logic           gt_reset_rx_datapath;
    logic           gt_reset_tx_datapath;
    logic [NCH-1:0] rx_serdes_reset;
    logic [NCH-1:0] tx_serdes_reset;
    logic [NCH-1:0] rx_core_reset;
    logic [NCH-1:0] tx_core_reset;

    int checks   = 0;
    int failures = 0;

    // Reference timeline parameters of the sequence currently in flight.
    logic [1:0] m_mode;
    logic [3:0] m_mask;
    logic [3:0] prev_core;
    int         k_rel;
    bit         success;
    int         te_rel = H + 2 + TO;

    typedef struct packed {
        logic       gt_all;
        logic       gt_rx;
        logic       gt_tx;
        logic [3:0] serdes;
        logic [3:0] core;
        logic       busy;
        logic       done_f;
        logic       timeout_f;
        logic [2:0] state;
    } exp_t;

    dcmac_reset_seq_if #(.NCH(NCH)) ctrl_if ();

    dcmac_reset_seq #(
        .NCH(NCH),
        .HOLD_CYCLES(H),
        .TIMEOUT_CYCLES(TO),
        .CW(CW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ctrl(ctrl_if),
        .rx_reset_done(rx_done),
        .tx_reset_done(tx_done),
        .gt_reset_all(gt_reset_all),
        .gt_reset_rx_datapath(gt_reset_rx_datapath),
        .gt_reset_tx_datapath(gt_reset_tx_datapath),
        .rx_serdes_reset(rx_serdes_reset),
        .tx_serdes_reset(tx_serdes_reset),
        .rx_core_reset(rx_core_reset),
        .tx_core_reset(tx_core_reset)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Expected outputs t cycles after the edge that accepted start.
    // Resets go high one edge after acceptance and stay for H+1 cycles;
    // core release, done and timeout follow from the done-arrival time.
    function automatic exp_t model(input int t);
        exp_t e;
        bit   core_only;
        bit   full;
        bit   ok_end;
        int   busy_end;
        e         = '0;
        core_only = (m_mode == 2'd2);
        full      = (m_mode == 2'd0) || (m_mode == 2'd3);
        if (!core_only && t >= 1 && t <= H + 1) begin
            e.gt_all = full;
            e.gt_rx  = 1'b1;
            e.gt_tx  = 1'b1;
            e.serdes = m_mask;
        end
        if (core_only)    busy_end = H + 2;
        else if (success) busy_end = k_rel + 1;
        else              busy_end = te_rel;
        ok_end      = core_only || success;
        e.busy      = (t < busy_end);
        e.done_f    = ok_end && (t >= busy_end);
        e.timeout_f = !ok_end && (t >= busy_end);
        if (t == 0)                         e.core = prev_core;
        else if (t < busy_end || !ok_end)   e.core = m_mask;
        else                                e.core = 4'h0;
        if (t == 0) e.state = 3'd1;
        else if (core_only) e.state = (t <= H) ? 3'd2 : ((t == H + 1) ? 3'd4 : 3'd0);
        else if (t <= H + 1) e.state = 3'd2;
        else if (success) e.state = (t < k_rel) ? 3'd3 : ((t == k_rel) ? 3'd4 : 3'd0);
        else e.state = (t < te_rel) ? 3'd3 : 3'd6;
        return e;
    endfunction

    task automatic compare(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input int t, input string ctx);
        exp_t  e;
        string p;
        e = model(t);
        p = $sformatf("%s t=%0d", ctx, t);
        compare({p, " gt_reset_all"}, {3'b000, gt_reset_all}, {3'b000, e.gt_all});
        compare({p, " gt_reset_rx_dp"}, {3'b000, gt_reset_rx_datapath}, {3'b000, e.gt_rx});
        compare({p, " gt_reset_tx_dp"}, {3'b000, gt_reset_tx_datapath}, {3'b000, e.gt_tx});
        compare({p, " rx_serdes"}, rx_serdes_reset, e.serdes);
        compare({p, " tx_serdes"}, tx_serdes_reset, e.serdes);
        compare({p, " rx_core"}, rx_core_reset, e.core);
        compare({p, " tx_core"}, tx_core_reset, e.core);
        compare({p, " busy"}, {3'b000, ctrl_if.busy}, {3'b000, e.busy});
        compare({p, " done"}, {3'b000, ctrl_if.done}, {3'b000, e.done_f});
        compare({p, " timeout"}, {3'b000, ctrl_if.timeout}, {3'b000, e.timeout_f});
        compare({p, " seq_state"}, {1'b0, ctrl_if.seq_state}, {1'b0, e.state});
    endtask

    task automatic checkZero(input string ctx);
        compare({ctx, " gt_reset_all"}, {3'b000, gt_reset_all}, 4'h0);
        compare({ctx, " gt_reset_rx_dp"}, {3'b000, gt_reset_rx_datapath}, 4'h0);
        compare({ctx, " gt_reset_tx_dp"}, {3'b000, gt_reset_tx_datapath}, 4'h0);
        compare({ctx, " rx_serdes"}, rx_serdes_reset, 4'h0);
        compare({ctx, " tx_serdes"}, tx_serdes_reset, 4'h0);
        compare({ctx, " rx_core"}, rx_core_reset, 4'h0);
        compare({ctx, " tx_core"}, tx_core_reset, 4'h0);
        compare({ctx, " busy"}, {3'b000, ctrl_if.busy}, 4'h0);
        compare({ctx, " done"}, {3'b000, ctrl_if.done}, 4'h0);
        compare({ctx, " timeout"}, {3'b000, ctrl_if.timeout}, 4'h0);
        compare({ctx, " seq_state"}, {1'b0, ctrl_if.seq_state}, 4'h0);
    endtask

    // One full sequence: start pulse, done flags driven d_rel cycles after
    // acceptance, optional stray start while busy, every cycle checked.
    task automatic applyStimulus(input logic [1:0] md, input logic [3:0] mk,
                                 input logic [3:0] rxv, input logic [3:0] txv,
                                 input int d_rel, input bit glitch, input string ctx);
        bit ok_done;
        int busy_end;
        int last_t;
        int t_glitch;
        m_mode  = md;
        m_mask  = mk;
        ok_done = (mk == 4'h0) || (((rxv & mk) == mk) && ((txv & mk) == mk));
        k_rel   = (mk == 4'h0 || d_rel + 3 < H + 3) ? H + 3 : d_rel + 3;
        success = ok_done && (k_rel <= te_rel);
        if (md == 2'd2)   busy_end = H + 2;
        else if (success) busy_end = k_rel + 1;
        else              busy_end = te_rel;
        last_t   = busy_end + 5;
        t_glitch = glitch ? $urandom_range(busy_end - 1, 0) : -1;

        ctrl_if.start     = 1'b1;
        ctrl_if.mode      = md;
        ctrl_if.chan_mask = mk;
        @(posedge clk);
        #1;
        for (int t = 0; t <= last_t; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            checkOutput(t, ctx);
            ctrl_if.mode      = 2'($urandom);
            ctrl_if.chan_mask = 4'($urandom);
            if (t == d_rel) begin
                rx_done = rxv;
                tx_done = txv;
            end
            if (t == last_t - 4) begin
                rx_done = '0;
                tx_done = '0;
            end
            ctrl_if.start = (t == t_glitch);
        end
        ctrl_if.start = 1'b0;
        prev_core = (md == 2'd2 || success) ? 4'h0 : mk;
    endtask

    initial begin
        logic [1:0] md;
        logic [3:0] mk;
        logic [3:0] rxv;
        logic [3:0] txv;
        ctrl_if.start     = 1'b0;
        ctrl_if.mode      = 2'd0;
        ctrl_if.chan_mask = '0;
        rx_done   = '0;
        tx_done   = '0;
        prev_core = '0;

        repeat (3) @(posedge clk);
        #1;
        checkZero("reset");
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkZero("idle");

        applyStimulus(2'd0, 4'b0101, 4'b0101, 4'b0101, 20, 1'b0, "full");
        applyStimulus(2'd2, 4'hF, 4'h0, 4'h0, 0, 1'b0, "core_only");
        applyStimulus(2'd0, 4'b0011, 4'h0, 4'h0, 0, 1'b0, "timeout");
        applyStimulus(2'd1, 4'b0011, 4'hF, 4'hF, 2, 1'b0, "after_timeout");
        applyStimulus(2'd0, 4'b0101, 4'b0101, 4'b0101, 20, 1'b1, "busy_start");
        applyStimulus(2'd1, 4'h0, 4'h0, 4'h0, 0, 1'b0, "mask_zero");
        applyStimulus(2'd3, 4'b1010, 4'hA, 4'hE, 5, 1'b0, "mode3");

        // Reset pulled low in the middle of HOLD.
        ctrl_if.start     = 1'b1;
        ctrl_if.mode      = 2'd0;
        ctrl_if.chan_mask = 4'hF;
        @(posedge clk);
        #1;
        ctrl_if.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checkZero("reset_mid_hold");
        ctrl_if.start = 1'b1;
        @(posedge clk);
        #1;
        checkZero("start_during_reset");
        ctrl_if.start = 1'b0;
        resetn        = 1'b1;
        @(posedge clk);
        #1;
        checkZero("after_reset_release");
        prev_core = '0;

        for (int i = 0; i < 20; i++) begin
            md  = 2'($urandom);
            mk  = 4'($urandom);
            rxv = ($urandom_range(3, 0) != 0) ? (mk | 4'($urandom)) : 4'($urandom);
            txv = ($urandom_range(3, 0) != 0) ? (mk | 4'($urandom)) : 4'($urandom);
            applyStimulus(md, mk, rxv, txv, $urandom_range(25, 0), 1'($urandom), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
